// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and iteration count for the iterative divider
package div_pkg;
   typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
   localparam int DIV_ITERS = 32;
endpackage

// File: rtl/cla.sv
// rtl/cla.sv - carry-lookahead adder, 4-bit lookahead groups chained group to group
module cla #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = cin;

   for (genvar k = 0; k < WIDTH / 4; k++) begin : g_blk
      localparam int B = 4 * k;
      assign c[B+1] = g[B] | (p[B] & c[B]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & c[B]);
      // The final carry-out is never consumed, so the top group stops here.
      if (k < WIDTH / 4 - 1) begin : g_cout
         assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B])
                       | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
      end
   end

   assign sum = p ^ c;
endmodule

// File: rtl/divu_iter.sv
// rtl/divu_iter.sv - restoring unsigned divider, one quotient bit per clock
module divu_iter
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);
   localparam logic [4:0] LAST_STEP = 5'(DIV_ITERS - 1);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             dbz_q, dbz_d;
   logic [4:0]       count_q, count_d;

   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] diff;
   logic             msb;
   logic             ge;

   // rem_q[MSB] is the 33rd bit of the shifted partial remainder.
   assign sh  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign msb = rem_q[WIDTH-1];

   cla #(.WIDTH(WIDTH)) u_sub (
      .a   (sh),
      .b   (~dvs_q),
      .cin (1'b1),
      .sum (diff)
   );

   assign ge = msb | (sh[WIDTH-1] & ~dvs_q[WIDTH-1])
             | (~(sh[WIDTH-1] ^ dvs_q[WIDTH-1]) & ~diff[WIDTH-1]);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      dbz_d   = dbz_q;
      count_d = count_q;
      case (state_q)
         DIV_IDLE: begin
            if (in_valid) begin
               rem_d   = '0;
               quo_d   = i_dividend;
               dvs_d   = i_divisor;
               dbz_d   = (i_divisor == '0);
               count_d = '0;
               state_d = DIV_RUN;
            end
         end
         DIV_RUN: begin
            rem_d   = ge ? diff : sh;
            quo_d   = {quo_q[WIDTH-2:0], ge};
            count_d = count_q + 5'd1;
            if (count_q == LAST_STEP) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (out_ready) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         dbz_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         dbz_q   <= dbz_d;
         count_q <= count_d;
      end
   end

   assign in_ready      = (state_q == DIV_IDLE);
   assign out_valid     = (state_q == DIV_DONE);
   assign o_quotient    = quo_q;
   assign o_remainder   = rem_q;
   assign o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_divu_iter.sv
// tb/tb_divu_iter.sv - self-checking bench for divu_iter
module tb_divu_iter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] i_dividend = '0;
   logic [31:0] i_divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] o_quotient;
   logic [31:0] o_remainder;
   logic        o_div_by_zero;

   always #5 clk = ~clk;

   divu_iter #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .i_dividend    (i_dividend),
      .i_divisor     (i_divisor),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .o_quotient    (o_quotient),
      .o_remainder   (o_remainder),
      .o_div_by_zero (o_div_by_zero)
   );

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      res_t        exp;
   } vec_t;

   res_t sb[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      res_t e;
      if (b == 0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         e.dbz = 1'b1;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input res_t e);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("accept_wait", {31'b0, in_ready}, 32'd1);
      in_valid   = 1'b1;
      i_dividend = a;
      i_divisor  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(e);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic compare_front(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb[0];
         check({tag, "_q"}, o_quotient, e.q);
         check({tag, "_r"}, o_remainder, e.r);
         check({tag, "_dbz"}, {31'b0, o_div_by_zero}, {31'b0, e.dbz});
      end
   endtask

   task automatic retire(input string tag, input int hold);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      compare_front(tag);
      if (sb.size() != 0) void'(sb.pop_front());
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input res_t e, input int hold);
      int lat;
      issue(a, b, e);
      wait_result(lat);
      check({tag, "_latency"}, 32'(lat), 32'd32);
      retire(tag, hold);
   endtask

   vec_t vecs[6];

   initial begin
      int lat;
      logic [31:0] a, b;

      vecs[0] = '{a: 32'd100,        b: 32'd7,          exp: '{q: 32'd14,        r: 32'd2,     dbz: 1'b0}};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          exp: '{q: 32'hFFFF_FFFF, r: 32'd0,     dbz: 1'b0}};
      vecs[2] = '{a: 32'd0,          b: 32'd5,          exp: '{q: 32'd0,         r: 32'd0,     dbz: 1'b0}};
      vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFE,  exp: '{q: 32'd1,         r: 32'd1,     dbz: 1'b0}};
      vecs[4] = '{a: 32'h8000_0001,  b: 32'h8000_0000,  exp: '{q: 32'd1,         r: 32'd1,     dbz: 1'b0}};
      vecs[5] = '{a: 32'd12345,      b: 32'd0,          exp: '{q: 32'hFFFF_FFFF, r: 32'd12345, dbz: 1'b1}};

      #1;
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_q", o_quotient, 32'd0);
      check("rst_r", o_remainder, 32'd0);
      check("rst_dbz", {31'b0, o_div_by_zero}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 6; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, i % 3);
      end

      // DONE held under backpressure while upstream keeps pulsing in_valid
      issue(32'd50, 32'd6, model(32'd50, 32'd6));
      wait_result(lat);
      check("hold_latency", 32'(lat), 32'd32);
      for (int i = 0; i < 20; i++) begin
         in_valid   = i[0];
         i_dividend = $urandom;
         i_divisor  = $urandom;
         @(posedge clk); #1;
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("hold_valid", {31'b0, out_valid}, 32'd1);
         compare_front("hold");
      end
      in_valid   = 1'b1;
      i_dividend = 32'd77;
      i_divisor  = 32'd7;
      out_ready  = 1'b1;
      if (sb.size() != 0) void'(sb.pop_front());
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("same_cycle_valid", {31'b0, out_valid}, 32'd0);
      check("same_cycle_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(model(32'd77, 32'd7));
      check("late_accept_ready", {31'b0, in_ready}, 32'd0);
      wait_result(lat);
      check("late_latency", 32'(lat), 32'd32);
      retire("late", 0);

      // Reset mid-run abandons the operation
      issue(32'd1000, 32'd3, model(32'd1000, 32'd3));
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort_valid", {31'b0, out_valid}, 32'd0);
      check("abort_q", o_quotient, 32'd0);
      check("abort_r", o_remainder, 32'd0);
      check("abort_dbz", {31'b0, o_div_by_zero}, 32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op("post_rst", 32'd9, 32'd3, '{q: 32'd3, r: 32'd0, dbz: 1'b0}, 0);

      for (int i = 0; i < 1500; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 63) == 0) b = 32'd0;
         run_op("rand", a, b, model(a, b), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
